// File: rtl/gamma_lut_writer.sv
// gamma_lut_writer: streams DEPTH table entries over a valid/ready handshake into
// the gamma luma LUT at consecutive addresses from 0, and raises oBusy so the gamma
// path keeps off the LUT while it is being reloaded.
// Define GAMMA_LUT_VERIFY_EN to compile in a readback pass that sums the table as
// read from the LUT and flags oError when that sum differs from the written sum.
module gamma_lut_writer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iStart,
  input  logic [DATA_W-1:0] iData,
  input  logic              iDataValid,
  output logic              oDataReady,
  output logic [ADDR_W-1:0] oLutAddr,
  output logic [DATA_W-1:0] oLutData,
  output logic              oLutWren,
  output logic              oLutRden,
  input  logic [DATA_W-1:0] iLutQ,
  output logic              oBusy,
  output logic              oDone,
  output logic              oError,
  output logic [23:0]       oChecksum
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = 24;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    VERIFY,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  wrCnt_q, wrCnt_d;
  logic [SUM_W-1:0]  wrSum_q, wrSum_d;
  logic [ADDR_W-1:0] lutAddr_q, lutAddr_d;
  logic [DATA_W-1:0] lutData_q, lutData_d;
  logic              lutWren_q, lutWren_d;
  logic [SUM_W-1:0]  checksum_q, checksum_d;
  logic              handshake;
  logic              lastWrite;

  assign handshake = (state_q == WRITE) && iDataValid;
  assign lastWrite = handshake && (wrCnt_q == LAST_IDX);

`ifdef GAMMA_LUT_VERIFY_EN
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  rdCnt_q, rdCnt_d;
  logic [CNT_W-1:0]  retCnt_q, retCnt_d;
  logic [SUM_W-1:0]  rdSum_q, rdSum_d;
  logic [RD_LAT-1:0] rdPipe_q, rdPipe_d;
  logic              lutRden_q, lutRden_d;
  logic              error_q, error_d;
  logic              rdReturn;
  logic              lastReturn;

  // The top bit of the read-valid pipe marks the cycle whose iLutQ belongs to a read.
  assign rdReturn   = rdPipe_q[RD_LAT-1];
  assign lastReturn = (state_q == VERIFY) && rdReturn && (retCnt_q == LAST_IDX);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: WRITE ends on the final handshake, VERIFY on the final read return
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (iStart) state_d = WRITE;
      end
      WRITE: begin
        if (lastWrite) begin
`ifdef GAMMA_LUT_VERIFY_EN
          state_d = VERIFY;
`else
          state_d = DONE;
`endif
        end
      end
      VERIFY: begin
`ifdef GAMMA_LUT_VERIFY_EN
        if (lastReturn) state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and datapath next-values: LUT write/read strobes, counters and sums
  always_comb begin
    wrCnt_d    = wrCnt_q;
    wrSum_d    = wrSum_q;
    lutAddr_d  = lutAddr_q;
    lutData_d  = lutData_q;
    lutWren_d  = 1'b0;
    checksum_d = checksum_q;
`ifdef GAMMA_LUT_VERIFY_EN
    rdCnt_d    = rdCnt_q;
    retCnt_d   = retCnt_q;
    rdSum_d    = rdSum_q;
    rdPipe_d   = RD_LAT'({rdPipe_q, lutRden_q});
    lutRden_d  = 1'b0;
    error_d    = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (iStart) begin
          wrCnt_d = '0;
          wrSum_d = '0;
`ifdef GAMMA_LUT_VERIFY_EN
          rdCnt_d  = '0;
          retCnt_d = '0;
          rdSum_d  = '0;
          error_d  = 1'b0;
`endif
        end
      end
      WRITE: begin
        if (handshake) begin
          lutAddr_d = ADDR_W'(wrCnt_q);
          lutData_d = iData;
          lutWren_d = 1'b1;
          wrSum_d   = wrSum_q + SUM_W'(iData);
          wrCnt_d   = wrCnt_q + CNT_W'(1);
`ifndef GAMMA_LUT_VERIFY_EN
          if (lastWrite) checksum_d = wrSum_d;
`endif
        end
      end
`ifdef GAMMA_LUT_VERIFY_EN
      VERIFY: begin
        if (rdCnt_q < DEPTH_CNT) begin
          lutRden_d = 1'b1;
          lutAddr_d = ADDR_W'(rdCnt_q);
          rdCnt_d   = rdCnt_q + CNT_W'(1);
        end
        if (rdReturn) begin
          rdSum_d  = rdSum_q + SUM_W'(iLutQ);
          retCnt_d = retCnt_q + CNT_W'(1);
        end
        if (lastReturn) begin
          checksum_d = wrSum_q;
          error_d    = (rdSum_d != wrSum_q);
        end
      end
`endif
      default: begin
      end
    endcase
  end

  // Datapath registers; reset clears every registered output
  always_ff @(posedge clk) begin
    if (reset) begin
      wrCnt_q    <= '0;
      wrSum_q    <= '0;
      lutAddr_q  <= '0;
      lutData_q  <= '0;
      lutWren_q  <= 1'b0;
      checksum_q <= '0;
`ifdef GAMMA_LUT_VERIFY_EN
      rdCnt_q    <= '0;
      retCnt_q   <= '0;
      rdSum_q    <= '0;
      rdPipe_q   <= '0;
      lutRden_q  <= 1'b0;
      error_q    <= 1'b0;
`endif
    end else begin
      wrCnt_q    <= wrCnt_d;
      wrSum_q    <= wrSum_d;
      lutAddr_q  <= lutAddr_d;
      lutData_q  <= lutData_d;
      lutWren_q  <= lutWren_d;
      checksum_q <= checksum_d;
`ifdef GAMMA_LUT_VERIFY_EN
      rdCnt_q    <= rdCnt_d;
      retCnt_q   <= retCnt_d;
      rdSum_q    <= rdSum_d;
      rdPipe_q   <= rdPipe_d;
      lutRden_q  <= lutRden_d;
      error_q    <= error_d;
`endif
    end
  end

  assign oDataReady = (state_q == WRITE);
  assign oBusy      = (state_q != IDLE);
  assign oDone      = (state_q == DONE);
  assign oLutAddr   = lutAddr_q;
  assign oLutData   = lutData_q;
  assign oLutWren   = lutWren_q;
  assign oChecksum  = checksum_q;

`ifdef GAMMA_LUT_VERIFY_EN
  assign oLutRden = lutRden_q;
  assign oError   = error_q;
`else
  // Without readback the LUT read port is left idle and its data is ignored.
  logic unusedLutQ;
  assign unusedLutQ = ^{iLutQ, RD_LAT[0]};
  assign oLutRden   = 1'b0;
  assign oError     = 1'b0;
`endif

endmodule

// File: doc/gamma_lut_writer.md
# gamma_lut_writer

Loader that programs the 4096-entry, 12-bit gamma luma LUT used by the gamma stage. It accepts a stream of table entries over a valid/ready handshake, writes them to consecutive LUT addresses starting at 0, and flags busy so the gamma path holds off LUT reads during a reload. Optionally it reads the table back and checks a checksum. It sits beside the gamma stage on the LUT's write/read port.

## Interface
Parameters:
- ADDR_W, 12, LUT address width
- DATA_W, 12, LUT entry width
- DEPTH, 4096, number of entries loaded per pass (≤ 2^ADDR_W)
- RD_LAT, 2, LUT read latency: cycles from oLutRden/oLutAddr to valid iLutQ

Ports:
- clk  in  1  clock; the single clock for the block
- reset  in  1  synchronous, active-high reset
- iStart  in  1  one-cycle request to begin a load; honoured only in IDLE
- iData  in  DATA_W  table entry
- iDataValid  in  1  iData valid
- oDataReady  out  1  block accepts iData this cycle
- oLutAddr  out  ADDR_W  LUT address (write or read)
- oLutData  out  DATA_W  LUT write data
- oLutWren  out  1  LUT write enable
- oLutRden  out  1  LUT read enable (verify only)
- iLutQ  in  DATA_W  LUT read data
- oBusy  out  1  load in progress; gamma LUT reads must be gated off
- oDone  out  1  one-cycle pulse at end of load
- oError  out  1  verify checksum mismatch; held until next accepted iStart
- oChecksum  out  24  sum of all entries written in the last load

## Operation
- FSM: IDLE → WRITE → (VERIFY) → DONE → IDLE.
- IDLE: oDataReady=0. iStart=1 clears the write counter, the write sum and oError, then enters WRITE.
- WRITE: oDataReady=1. A handshake occurs when iDataValid & oDataReady. On each handshake:
  - register oLutAddr=wcnt, oLutData=iData, oLutWren=1 for exactly the next cycle;
  - add iData (zero-extended) to the 24-bit write sum;
  - increment wcnt.
- Leave WRITE after handshake DEPTH-1. The sum is exact because DEPTH·(2^12−1) < 2^24.
- No handshake in a cycle: oLutWren=0 next cycle, and the counter holds.
- VERIFY (macro only): one idle cycle after the last write, then issue reads of addr 0..DEPTH-1 on consecutive cycles with oLutRden=1. Accumulate iLutQ RD_LAT cycles after each read into a read sum.
- DONE: lasts 1 cycle with oDone=1. oChecksum updates to the write sum. In verify builds, oError=(read sum ≠ write sum).
- oBusy=1 in WRITE, VERIFY and DONE.
- iStart outside IDLE (including DONE) is ignored; it does not restart the load.
- Reset mid-load returns to IDLE. The table is left partially written and oDone is not pulsed.

## Timing
- Reset values: oDataReady, oLutAddr, oLutData, oLutWren, oLutRden, oBusy, oDone, oError, oChecksum all 0.
- Cycle 0: iStart sampled in IDLE. From cycle 1: oBusy=1, oDataReady=1.
- Handshake-to-write latency is 1 cycle. Entry k is written in the cycle after its handshake.
- Valid every cycle, no verify: handshakes in cycles 1..DEPTH; oDone=1 in cycle DEPTH+1, in the same cycle as the last write; oBusy falls in cycle DEPTH+2.
- Valid every cycle, with verify:
  - reads issued in cycles DEPTH+2..2·DEPTH+1;
  - oDone and final oError in cycle 2·DEPTH+2+RD_LAT, which is 8196 at default parameters.
- oLutWren and oLutRden are never high in the same cycle.

## Configuration
- GAMMA_LUT_VERIFY_EN defined: VERIFY state, readback reads, read-sum accumulator and oError comparison are compiled in.
- Not defined: WRITE goes directly to DONE. oLutRden and oError are tied to 0, and no read logic exists.

## Test plan
- Reset, with iStart and iDataValid held high during reset → all outputs 0 throughout, FSM stays IDLE.
- iStart, iData=k for k=0..4095, iDataValid=1 every cycle (no verify) → exactly 4096 writes with addr=k and data=k, in cycles 2..4097 (each write one cycle after its handshake); oDone in cycle 4097; oChecksum=0x7FF800.
- iDataValid high only on odd cycles → writes only after handshakes, addresses contiguous 0..4095; oDone in cycle 8192.
- iStart pulsed at cycles 50 and 4097 during a load → no restart, addresses continue unbroken; second pulse ignored; IDLE at cycle 4098.
- Reset at entry 100 → all outputs 0 next cycle, no oDone; a following iStart rewrites from addr 0.
- Verify build, RD_LAT=2:
  - bench LUT model returns +1 at addr 5 → oError=1 with oDone in cycle 8196;
  - clean model → oError=0 in cycle 8196.
